mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised up/down counter with a programmable modulus (upper limit) and a programmable step.
- Selectable wrap or saturate mode at the limits.
- Terminal-count pulse and a sticky overflow flag.
- Intended as the general-purpose counter in the library, used for datapath loop indices, timers and address generators.

Parameters:
WIDTH, 8, bit width of count value, limit, step and load data

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_L  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of Q (active high)
load  input  1  synchronous parallel load
D  input  WIDTH  load data
en  input  1  count enable
up  input  1  direction: 1 = up, 0 = down
step  input  WIDTH  increment/decrement amount
limit  input  WIDTH  maximum count value; legal range is [0, limit]
sat  input  1  1 = saturate at limits, 0 = wrap modulo (limit+1)
ovf_clr  input  1  clears sticky overflow flag
Q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
ovf  output  1  sticky boundary-event flag (registered)

Behaviour:
- Reset:
  - reset_L low immediately forces Q=0, tc=0 and ovf=0, independent of clock.
  - This holds even in the middle of a count.
  - The first update after release occurs on the first rising edge with reset_L high.
- Priority per edge is clear > load > count.
  - clear and load act regardless of en.
  - A count happens only when en=1 and clear=0 and load=0.
- clear: Q <= 0; tc <= 0; ovf unchanged.
- load: Q <= min(D, limit); tc <= 0; no boundary event.
- Internal arithmetic:
  - All internal arithmetic is WIDTH+1 bits wide.
  - M = limit+1.
  - step_eff = min(step, M).
- Up count: n = Q + step_eff.
  - If n <= limit: Q <= n.
  - Otherwise boundary event: wrap gives Q <= n - M; sat gives Q <= limit.
- Down count:
  - If Q >= step_eff: Q <= Q - step_eff.
  - Otherwise boundary event: wrap gives Q <= Q + M - step_eff; sat gives Q <= 0.
- Out of range:
  - If Q > limit at a count edge (limit was lowered), Q <= limit in either direction and either mode.
  - This counts as a boundary event.
- Zero limit: limit=0 keeps Q at 0, and every count edge is a boundary event.
- Zero step: step=0 leaves Q unchanged; no boundary event unless Q is out of range.
- tc:
  - tc <= 1 on the edge where a boundary event occurs; otherwise tc <= 0.
  - One-cycle pulse; it stays high across consecutive boundary events.
- ovf:
  - Set by a boundary event and cleared by ovf_clr.
  - If both occur on the same edge, set wins.
- Latency: all outputs are registered, one edge after inputs are sampled; Q has no combinational path from inputs.

Optional Feature:
MOD_COUNTER_CASCADE_EN
- Defined:
  - Adds input cin (1 bit) and output cout (1 bit).
  - A count occurs only when en=1 and cin=1.
  - cout is combinational: en & cin & ~clear & ~load & (boundary event would occur on this edge).
  - This lets stages be chained by connecting cout to the next stage's cin.
- Undefined: cin and cout ports are absent; behaviour is identical to cin tied to 1.

Test Plan:
1. Async reset mid-count: WIDTH=8, Q=37, drop reset_L between edges -> Q=0, tc=0 and ovf=0 before the next edge.
2. Wrap up: limit=9, step=1, sat=0, Q=9, en=1, up=1 -> Q=0, tc high exactly one cycle, ovf=1; ovf_clr pulse -> ovf=0.
3. Multi-step wrap, both directions (limit=9, step=4, sat=0):
   - Q=8, up -> Q=2.
   - Then down from Q=1 -> Q=7.
   - Then step=15 (clamped to 10), up from Q=7 -> Q=7, tc=1.
4. Saturate down: limit=200, step=5, sat=1, Q=3, up=0 -> Q=0, tc=1; next edge Q=0, tc=1 again; step=0 -> Q=0, tc=0.
5. Priority and clamp:
   - clear=1, load=1, en=1 -> Q=0.
   - load with D=250, limit=100 -> Q=100, tc=0.
   - Then lower limit to 50 and count up -> Q=50, tc=1.
6. Set-wins: boundary event and ovf_clr on the same edge -> ovf=1; with MOD_COUNTER_CASCADE_EN, two 4-bit stages (limit=9) count 0..99 with cout pulsing at Q=9 of the low stage.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: general-purpose up/down counter.
//   The modulus (limit) and the step are programmable at run time.
//   At the limits the counter either wraps or saturates.
//   It produces a terminal-count pulse and a sticky overflow flag.
//
// Optional feature macro: MOD_COUNTER_CASCADE_EN
//   Adds cin and cout so that stages can be chained.
//   When the macro is undefined, the counter behaves as if cin were tied to 1.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset_L  asynchronous active-low reset (clears Q, tc and ovf)
//   clear    synchronous clear of Q; highest priority
//   load     synchronous load of min(D, limit)
//   D        load data
//   en       count enable
//   up       count direction (1 = up, 0 = down)
//   step     increment/decrement amount, clamped to limit+1
//   limit    largest legal count value
//   sat      1 = saturate at the limits, 0 = wrap modulo limit+1
//   ovf_clr  clears the sticky overflow flag (a same-edge boundary event wins)
//   Q        registered count
//   tc       registered pulse on every boundary event
//   ovf      registered sticky boundary-event flag
//   cin      (cascade only) carry in; counting also requires cin=1
//   cout     (cascade only) combinational: a count edge is about to hit a boundary
`default_nettype none

module mod_updown_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             ovf_clr,
`ifdef MOD_COUNTER_CASCADE_EN
  input  logic             cin,
  output logic             cout,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  // One extra bit so that limit+1 and the sums below never overflow.
  localparam int unsigned XW = WIDTH + 1;

  logic             cin_c;
  logic             count_c;
  logic [XW-1:0]    q_x;
  logic [XW-1:0]    lim_x;
  logic [XW-1:0]    mod_x;
  logic [XW-1:0]    step_x;
  logic [XW-1:0]    step_eff;
  logic [XW-1:0]    sum_x;
  logic [XW-1:0]    cnt_nxt_x;
  logic             bnd_c;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

`ifdef MOD_COUNTER_CASCADE_EN
  assign cin_c = cin;
`else
  assign cin_c = 1'b1;
`endif

  // A count happens only when no clear or load takes precedence.
  assign count_c = en & cin_c & ~clear & ~load;

`ifdef MOD_COUNTER_CASCADE_EN
  assign cout = count_c & bnd_c;
`endif

  // Widened operands, modulus and clamped step.
  always_comb begin
    q_x      = XW'(Q);
    lim_x    = XW'(limit);
    mod_x    = lim_x + XW'(1);
    step_x   = XW'(step);
    step_eff = (step_x > mod_x) ? mod_x : step_x;
  end

  // Count arithmetic: next value if counting, plus boundary-event detect.
  always_comb begin
    sum_x     = '0;
    cnt_nxt_x = q_x;
    bnd_c     = 1'b0;
    if (lim_x == '0) begin
      // A zero modulus pins the count at 0; every count edge is a boundary.
      cnt_nxt_x = '0;
      bnd_c     = 1'b1;
    end else if (q_x > lim_x) begin
      // The limit was lowered below Q: snap to the limit.
      cnt_nxt_x = lim_x;
      bnd_c     = 1'b1;
    end else if (up) begin
      sum_x = q_x + step_eff;
      if (sum_x <= lim_x) begin
        cnt_nxt_x = sum_x;
      end else begin
        bnd_c     = 1'b1;
        cnt_nxt_x = sat ? lim_x : (sum_x - mod_x);
      end
    end else begin
      if (q_x >= step_eff) begin
        cnt_nxt_x = q_x - step_eff;
      end else begin
        bnd_c     = 1'b1;
        sum_x     = q_x + mod_x;
        cnt_nxt_x = sat ? '0 : (sum_x - step_eff);
      end
    end
  end

  // Next-state selection with clear > load > count priority.
  always_comb begin
    q_nxt   = Q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end
    if (clear) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (D > limit) ? limit : D;
    end else if (count_c) begin
      q_nxt  = WIDTH'(cnt_nxt_x);
      tc_nxt = bnd_c;
      if (bnd_c) begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      Q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      Q   <= q_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// Directed testbench for mod_updown_counter.
// Expected values in this bench are computed by hand.
`timescale 1ns/1ps

module tb_mod_updown_counter;

  localparam int unsigned WIDTH = 8;

  logic             clock;
  logic             reset_L;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] D;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic             ovf_clr;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             ovf;

  int n_checks;
  int n_fail;

`ifdef MOD_COUNTER_CASCADE_EN
  logic       cout;
  logic       lo_cout;
  logic       hi_cout;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_tc;
  logic       lo_ovf;
  logic       hi_tc;
  logic       hi_ovf;
  logic       cas_clear;
  logic       cas_en;
`endif

  mod_updown_counter #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (clear),
    .load    (load),
    .D       (D),
    .en      (en),
    .up      (up),
    .step    (step),
    .limit   (limit),
    .sat     (sat),
    .ovf_clr (ovf_clr),
`ifdef MOD_COUNTER_CASCADE_EN
    .cin     (1'b1),
    .cout    (cout),
`endif
    .Q       (Q),
    .tc      (tc),
    .ovf     (ovf)
  );

`ifdef MOD_COUNTER_CASCADE_EN
  mod_updown_counter #(.WIDTH(4)) u_lo (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (cas_clear),
    .load    (1'b0),
    .D       (4'd0),
    .en      (cas_en),
    .up      (1'b1),
    .step    (4'd1),
    .limit   (4'd9),
    .sat     (1'b0),
    .ovf_clr (1'b0),
    .cin     (1'b1),
    .cout    (lo_cout),
    .Q       (lo_q),
    .tc      (lo_tc),
    .ovf     (lo_ovf)
  );

  mod_updown_counter #(.WIDTH(4)) u_hi (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (cas_clear),
    .load    (1'b0),
    .D       (4'd0),
    .en      (cas_en),
    .up      (1'b1),
    .step    (4'd1),
    .limit   (4'd9),
    .sat     (1'b0),
    .ovf_clr (1'b0),
    .cin     (lo_cout),
    .cout    (hi_cout),
    .Q       (hi_q),
    .tc      (hi_tc),
    .ovf     (hi_ovf)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk3(input string tag, input int q_e, input int tc_e, input int ovf_e);
    check({tag, ".Q"},   32'(Q),   32'(q_e));
    check({tag, ".tc"},  32'(tc),  32'(tc_e));
    check({tag, ".ovf"}, 32'(ovf), 32'(ovf_e));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_L = 1'b0; clear = 1'b0; load = 1'b0; D = '0; en = 1'b0; up = 1'b1;
    step = 8'd1; limit = 8'd200; sat = 1'b0; ovf_clr = 1'b0;
`ifdef MOD_COUNTER_CASCADE_EN
    cas_clear = 1'b1; cas_en = 1'b0;
`endif
    tick(); tick();
    chk3("reset", 0, 0, 0);
    reset_L = 1'b1;

    // 1. Async reset while mid-count with tc/ovf set.
    load = 1'b1; D = 8'd37; tick();
    chk3("t1_load", 37, 0, 0);
    load = 1'b0; en = 1'b1; tick();
    chk3("t1_cnt", 38, 0, 0);
    limit = 8'd30; tick();
    chk3("t1_oor", 30, 1, 1);
    reset_L = 1'b0; #2;
    chk3("t1_async", 0, 0, 0);
    en = 1'b0; limit = 8'd200;
    tick();
    reset_L = 1'b1;
    en = 1'b1; tick();
    chk3("t1_release", 1, 0, 0);

    // 2. Wrap up at limit 9, then ovf_clr.
    en = 1'b0; limit = 8'd9; step = 8'd1; sat = 1'b0; up = 1'b1;
    load = 1'b1; D = 8'd9; tick();
    chk3("t2_load", 9, 0, 0);
    load = 1'b0; en = 1'b1; tick();
    chk3("t2_wrap", 0, 1, 1);
    tick();
    chk3("t2_next", 1, 0, 1);
    en = 1'b0; ovf_clr = 1'b1; tick();
    chk3("t2_ovfclr", 1, 0, 0);
    ovf_clr = 1'b0;

    // 3. Multi-step wrap both ways, and step clamped to the modulus.
    step = 8'd4; load = 1'b1; D = 8'd8; tick();
    chk3("t3_load8", 8, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk3("t3_up", 2, 1, 1);
    load = 1'b1; D = 8'd1; tick();
    chk3("t3_load1", 1, 0, 1);
    load = 1'b0; up = 1'b0; tick();
    chk3("t3_down", 7, 1, 1);
    step = 8'd15; up = 1'b1; tick();
    chk3("t3_bigstep", 7, 1, 1);

    // 4. Saturation both ways.
    en = 1'b0; limit = 8'd200; step = 8'd5; sat = 1'b1;
    load = 1'b1; D = 8'd3; tick();
    load = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk3("t4_satdn", 0, 1, 1);
    tick();
    chk3("t4_satdn2", 0, 1, 1);
    step = 8'd0; tick();
    chk3("t4_step0", 0, 0, 1);
    step = 8'd5; up = 1'b1; load = 1'b1; D = 8'd198; tick();
    chk3("t4_load198", 198, 0, 1);
    load = 1'b0; tick();
    chk3("t4_satup", 200, 1, 1);

    // 5. Priority and load clamp, then lowered limit.
    sat = 1'b0; step = 8'd1;
    clear = 1'b1; load = 1'b1; D = 8'd50; en = 1'b1; tick();
    chk3("t5_clr_pri", 0, 0, 1);
    clear = 1'b0; load = 1'b1; D = 8'd250; limit = 8'd100; tick();
    chk3("t5_clamp", 100, 0, 1);
    load = 1'b0; limit = 8'd50; up = 1'b1; tick();
    chk3("t5_lowered", 50, 1, 1);
    en = 1'b0; clear = 1'b1; tick();
    chk3("t5_clear_noen", 0, 0, 1);
    clear = 1'b0;

    // 6. Set wins over ovf_clr on the same edge.
    ovf_clr = 1'b1; tick();
    chk3("t6_pre", 0, 0, 0);
    ovf_clr = 1'b0; limit = 8'd9; load = 1'b1; D = 8'd9; tick();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1; tick();
    chk3("t6_setwins", 0, 1, 1);
    en = 1'b0; tick();
    chk3("t6_clr", 0, 0, 0);
    ovf_clr = 1'b0;

    // Zero limit: Q stays at 0 and every count is a boundary.
    limit = 8'd0; load = 1'b1; D = 8'd5; tick();
    chk3("z_load", 0, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk3("z_up", 0, 1, 1);
    up = 1'b0; tick();
    chk3("z_dn", 0, 1, 1);
    en = 1'b0; tick();
    chk3("z_idle", 0, 0, 1);

`ifdef MOD_COUNTER_CASCADE_EN
    // Two decade stages chained through cout -> cin count 0..99 and wrap.
    cas_clear = 1'b0; cas_en = 1'b1;
    for (int i = 0; i < 101; i++) begin
      check("cas_lo", 32'(lo_q), 32'(i % 10));
      check("cas_hi", 32'(hi_q), 32'((i / 10) % 10));
      check("cas_cout", 32'(lo_cout), 32'((i % 10) == 9));
      tick();
    end
    cas_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
